// File: rtl/seq_reduce.sv
// seq_reduce: frames of N signed numbers reduced to a single signed result
// (sum / max / min / range), emitted as a one-cycle pulse after the frame.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | no frame open, count = 0
// S_COLLECT | frame open, 1..N-1 numbers accepted, waiting for the rest
module seq_reduce #(
  parameter int W     = 4,
  parameter int N     = 6,
  parameter int OUT_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [W-1:0]     in_number,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_result
);

  localparam int CNT_W = $clog2(N);
  localparam int SUM_W = W + $clog2(N) + 1;
  // Internal width wide enough for the full-precision sum and for the
  // saturation bounds, plus a guard bit so comparisons never wrap.
  localparam int CW    = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

  localparam logic [CNT_W-1:0]     LAST    = CNT_W'(N - 1);
  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_COLLECT} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic signed [CW-1:0]    acc_q, acc_d;
  logic signed [W-1:0]     max_q, max_d;
  logic signed [W-1:0]     min_q, min_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_result_q, out_result_d;

  logic signed [CW-1:0]    in_ext;
  logic signed [CW-1:0]    sum_c;
  logic signed [CW-1:0]    rng_c;
  logic signed [W-1:0]     max_c;
  logic signed [W-1:0]     min_c;
  logic                    first_c;
  logic                    last_c;

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [CW-1:0] v);
    if (v > SAT_MAX) begin
      sat = SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      sat = SAT_MIN[OUT_W-1:0];
    end else begin
      sat = v[OUT_W-1:0];
    end
  endfunction

  assign in_ext  = {{(CW-W){in_number[W-1]}}, in_number};
  assign first_c = (state_q == S_IDLE) && in_valid;
  assign last_c  = (state_q == S_COLLECT) && in_valid && (cnt_q == LAST);

  // Running values including the number presented this cycle; on the
  // closing number these are the frame's final sum/max/min.
  assign sum_c = acc_q + in_ext;
  assign max_c = (in_number > max_q) ? in_number : max_q;
  assign min_c = (in_number < min_q) ? in_number : min_q;
  assign rng_c = {{(CW-W){max_c[W-1]}}, max_c} - {{(CW-W){min_c[W-1]}}, min_c};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a gap in in_valid or the N-th number closes the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid) state_d = S_COLLECT;
      S_COLLECT: if (!in_valid || (cnt_q == LAST)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: first number seeds everything, later ones fold in.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    acc_d  = acc_q;
    max_d  = max_q;
    min_d  = min_q;
    if (first_c) begin
      cnt_d  = CNT_W'(1);
      mode_d = mode;
      acc_d  = in_ext;
      max_d  = in_number;
      min_d  = in_number;
    end else if (state_q == S_COLLECT) begin
      if (!in_valid || last_c) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum_c;
        max_d = max_c;
        min_d = min_c;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= '0;
      acc_q  <= '0;
      max_q  <= '0;
      min_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      acc_q  <= acc_d;
      max_q  <= max_d;
      min_q  <= min_d;
    end
  end

  // Output logic: result selected by the latched mode on the closing number.
  always_comb begin
    out_valid_d  = last_c;
    out_result_d = '0;
    if (last_c) begin
      case (mode_q)
        2'b00:   out_result_d = sat(sum_c);
        2'b01:   out_result_d = {{(OUT_W-W){max_c[W-1]}}, max_c};
        2'b10:   out_result_d = {{(OUT_W-W){min_c[W-1]}}, min_c};
        default: out_result_d = sat(rng_c);
      endcase
    end
  end

  // Output registers give the one-cycle latency and the zero-when-idle result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_seq_reduce.sv
// tb_seq_reduce: directed frames with hand-computed results for seq_reduce
// (W=4, N=6, OUT_W=6). Inputs change on the falling edge, outputs are
// checked on the falling edge.
module tb_seq_reduce;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [3:0] in_number;
  logic [1:0]        mode;
  logic              out_valid;
  logic signed [5:0] out_result;

  int n_vec  = 0;
  int n_err  = 0;
  int pulses = 0;
  int p0;
  int fv[6];

  always #5 clk = ~clk;

  seq_reduce #(.W(4), .N(6), .OUT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_number  (in_number),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_result (out_result)
  );

  // Count rising edges of out_valid to catch stray or missing pulses.
  always @(posedge out_valid) pulses++;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic signed [3:0] n, input logic [1:0] m);
    in_valid  = v;
    in_number = n;
    mode      = m;
  endtask

  // Drive fv[] as one frame (mode m0 on the first number, m1 afterwards),
  // then expect a single pulse carrying exp.
  task automatic frame(input string tag, input logic [1:0] m0, input logic [1:0] m1,
                       input int exp);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i > 0) check({tag, "_nopulse"}, 32'(out_valid), 0);
      drv(1'b1, 4'(fv[i]), (i == 0) ? m0 : m1);
    end
    tick();
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_result"}, 32'(out_result), exp);
    drv(1'b0, 4'sd0, 2'b00);
    tick();
    check({tag, "_drop"}, 32'(out_valid), 0);
    check({tag, "_zero"}, 32'(out_result), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drv(1'b0, 4'sd0, 2'b00);
    tick();
    tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_result", 32'(out_result), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_valid", 32'(out_valid), 0);
    check("idle_result", 32'(out_result), 0);
    check("idle_pulses", pulses, 0);

    fv = '{1, 2, 3, -1, 4, 5};
    frame("sum", 2'b00, 2'b00, 14);
    fv = '{7, 7, 7, 7, 7, 7};
    frame("sat_hi", 2'b00, 2'b00, 31);
    fv = '{-8, -8, -8, -8, -8, -8};
    frame("sat_lo", 2'b00, 2'b00, -32);

    fv = '{3, -5, 7, 0, -8, 2};
    frame("max", 2'b01, 2'b01, 7);
    frame("min", 2'b10, 2'b10, -8);
    frame("range", 2'b11, 2'b11, 15);
    frame("latch", 2'b01, 2'b10, 7);

    // Aborted frame of three numbers, then a full frame of ones.
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      tick();
      drv(1'b1, 4'sd1, 2'b00);
    end
    tick();
    drv(1'b0, 4'sd0, 2'b00);
    repeat (3) tick();
    check("abort_nopulse", pulses - p0, 0);
    fv = '{1, 1, 1, 1, 1, 1};
    frame("after_abort", 2'b00, 2'b00, 6);
    check("abort_single", pulses - p0, 1);

    // Back-to-back max then min frames, third frame cut by reset.
    p0 = pulses;
    fv = '{3, -5, 7, 0, -8, 2};
    for (int i = 0; i < 6; i++) begin
      tick();
      drv(1'b1, 4'(fv[i]), 2'b01);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        check("b2b_a_valid", 32'(out_valid), 1);
        check("b2b_a_result", 32'(out_result), 7);
      end else begin
        check("b2b_b_nopulse", 32'(out_valid), 0);
      end
      drv(1'b1, 4'(fv[i]), 2'b10);
    end
    tick();
    check("b2b_b_valid", 32'(out_valid), 1);
    check("b2b_b_result", 32'(out_result), -8);
    drv(1'b1, 4'sd1, 2'b00);
    tick();
    check("b2b_c_nopulse", 32'(out_valid), 0);
    drv(1'b1, 4'sd1, 2'b00);
    tick();
    drv(1'b1, 4'sd1, 2'b00);
    #2 rst = 1'b1;
    #1 check("b2b_rst_valid", 32'(out_valid), 0);
    tick();
    drv(1'b0, 4'sd0, 2'b00);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("b2b_pulses", pulses - p0, 2);
    fv = '{1, 1, 1, 1, 1, 1};
    frame("post_rst", 2'b00, 2'b00, 6);

    // Reset landing in the out_valid cycle clears the outputs at once.
    p0 = pulses;
    fv = '{1, 2, 3, -1, 4, 5};
    for (int i = 0; i < 6; i++) begin
      tick();
      drv(1'b1, 4'(fv[i]), 2'b00);
    end
    tick();
    drv(1'b0, 4'sd0, 2'b00);
    check("rov_valid", 32'(out_valid), 1);
    check("rov_result", 32'(out_result), 14);
    #2 rst = 1'b1;
    #1;
    check("rov_valid_clr", 32'(out_valid), 0);
    check("rov_result_clr", 32'(out_result), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rov_after", 32'(out_valid), 0);
    check("rov_pulses", pulses - p0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_reduce.md
SEQ_REDUCE -- requirements
Module: seq_reduce

Interface
REQ-001 Parameter W, default 4, width of each signed two's-complement input number.
REQ-002 Parameter N, default 6, numbers per frame; N SHALL be >= 2.
REQ-003 Parameter OUT_W, default 6, signed result width; OUT_W SHALL be >= W+1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  high while a frame number is presented.
REQ-007 in_number  input  W  signed input number, valid when in_valid=1.
REQ-008 mode  input  2  reduction select, sampled on first number of a frame only.
REQ-009 out_valid  output  1  one-cycle pulse marking a valid result.
REQ-010 out_result  output  OUT_W  signed frame result.

Function
REQ-011 Frame: exactly N consecutive cycles with in_valid=1; numbers accepted one per cycle.
REQ-012 Modes: 00 signed sum; 01 maximum; 10 minimum; 11 range (maximum minus minimum).
REQ-013 Mode latched on the frame's first accepted number; mode changes later in the frame SHALL be ignored.
REQ-014 States: IDLE (no frame open, count=0) and COLLECT (count 1..N-1 numbers accepted).
REQ-015 IDLE->COLLECT on in_valid=1; COLLECT stays on in_valid=1 while count<N-1.
REQ-016 The N-th accepted number SHALL close the frame: return to IDLE, count=0.
REQ-017 out_valid SHALL pulse high for exactly one cycle, the cycle after the N-th number is accepted (latency 1).
REQ-018 out_result SHALL hold the frame result while out_valid=1 and SHALL be 0 whenever out_valid=0.
REQ-019 Sum SHALL be accumulated at full internal precision (W+clog2(N) bits min), then saturated to OUT_W signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-020 Max/min SHALL compare signed; range SHALL be computed non-negative and saturated to 2^(OUT_W-1)-1 if exceeded.
REQ-021 Abort: in_valid=0 while in COLLECT SHALL discard the partial frame, return to IDLE, and produce no out_valid.
REQ-022 Back-to-back: in_valid=1 in the cycle after the N-th number SHALL start a new frame; the previous frame's out_valid pulse occurs in that same cycle, unaffected.
REQ-023 Accumulator, max and min registers SHALL be re-initialised from the first number of each frame, never carried across frames.
REQ-024 No result, partial or otherwise, SHALL be emitted for a frame shorter than N.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force IDLE, count=0, out_valid=0, out_result=0, internal accumulators cleared.
REQ-026 Reset mid-frame SHALL discard the frame; after rst deasserts, the next in_valid=1 starts a fresh frame.
REQ-027 Reset during the out_valid cycle SHALL force out_valid=0 at once; that result is lost.

Verification (W=4, N=6, OUT_W=6)
REQ-028 rst pulse, no stimulus -> out_valid=0, out_result=0 throughout and after release.
REQ-029 mode=00, inputs 1,2,3,-1,4,5 -> out_valid one cycle after 6th input, out_result=14.
REQ-030 mode=00, six x 7 -> 31 (saturated); mode=00, six x -8 -> -32 (saturated).
REQ-031 inputs 3,-5,7,0,-8,2 with mode=01 -> 7; mode=10 -> -8; mode=11 -> 15; mode toggled after first input -> original mode's result.
REQ-032 in_valid low after 3 inputs, then full mode=00 frame 1,1,1,1,1,1 -> no pulse for the aborted frame, single pulse out_result=6.
REQ-033 two back-to-back frames (mode=01 then 10, no gap), rst asserted mid-third-frame -> pulses 7 then -8 on correct cycles, no pulse for the third frame, out_valid=0 immediately on rst.
